// File: rtl/shift_reg_pkg.sv
// Shared types and defaults for the shift-register loader.
//   state_e        : loader FSM states
//   SEL_DYN/STAT   : CMD_SEL encodings for the two latch banks
//   *_DEF          : default geometry of the pixel chain
//   cnt_w()        : counter width for a modulo-n counter (never below 1 bit)
package shift_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic SEL_DYN  = 1'b0;
  localparam logic SEL_STAT = 1'b1;

  localparam int unsigned FRAME_W_DEF = 16;
  localparam int unsigned N_DYN_DEF   = 16;
  localparam int unsigned N_STAT_DEF  = 88;

  // Width holding values 0..n-1; FRAME_W = 2**k needs exactly k bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_sck_gen.sv
// Shift-clock generator: SCK low for CLK_DIV cycles, then high for CLK_DIV
// cycles, repeating while enabled. Held low and cleared when disabled.
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset
//   en_i         : run the generator (loader in SHIFT)
//   sck_o        : registered shift clock
//   rise_tick_c  : high in the cycle whose closing edge raises SCK
//   fall_tick_c  : high in the cycle whose closing edge lowers SCK (bit end)
module shift_reg_sck_gen
  import shift_reg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned DIV_W = cnt_w(CLK_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             half_end_c;

  assign half_end_c  = (cnt_q == DIV_W'(CLK_DIV - 1));
  assign rise_tick_c = en_i && half_end_c && !sck_q;
  assign fall_tick_c = en_i && half_end_c && sck_q;

  // Half-period counter; SCK toggles at the end of every half period.
  always_comb begin
    cnt_d = '0;
    sck_d = 1'b0;
    if (en_i) begin
      if (half_end_c) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
        sck_d = sck_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/shift_reg_loader.sv
// Config-frame loader for the pixel shift-register chain. Accepts a frame on
// a valid/ready handshake, shifts it MSB-first on SDO/SCK, strobes one
// addressed latch in the dynamic or static bank, then pulses ENFIN.
//   CLK, RST              : clock, synchronous active-high reset
//   CMD_VALID/CMD_READY   : request handshake (READY only in IDLE)
//   CMD_DATA/SEL/ADDR     : frame payload, bank select, latch index
//   SDO, SCK              : serial data and shift clock
//   DYNLATCH, STATLATCH   : one-hot latch strobes
//   ENFIN                 : one-cycle end-of-frame pulse
//   BUSY                  : high outside IDLE
//   ERR                   : one-cycle pulse on an out-of-range address
// Optional feature macro SHIFT_READBACK_EN adds SDI, RD_DATA, RD_VALID: SDI is
// captured on each SCK rise and the returned frame is presented with ENFIN.
module shift_reg_loader
  import shift_reg_pkg::*;
#(
  parameter int unsigned FRAME_W   = FRAME_W_DEF,
  parameter int unsigned N_DYN     = N_DYN_DEF,
  parameter int unsigned N_STAT    = N_STAT_DEF,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned LATCH_CYC = 2,
  parameter int unsigned ADDR_W    = 7
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [FRAME_W-1:0] CMD_DATA,
  input  logic               CMD_SEL,
  input  logic [ADDR_W-1:0]  CMD_ADDR,
  output logic               SDO,
  output logic               SCK,
  output logic [N_DYN-1:0]   DYNLATCH,
  output logic [N_STAT-1:0]  STATLATCH,
  output logic               ENFIN,
  output logic               BUSY,
`ifdef SHIFT_READBACK_EN
  input  logic               SDI,
  output logic [FRAME_W-1:0] RD_DATA,
  output logic               RD_VALID,
`endif
  output logic               ERR
);

  localparam int unsigned BIT_W = cnt_w(FRAME_W);
  localparam int unsigned LAT_W = cnt_w(LATCH_CYC);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               sel_q, sel_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               sdo_q, sdo_d;
  logic [N_DYN-1:0]   dyn_q, dyn_d;
  logic [N_STAT-1:0]  stat_q, stat_d;
  logic               enfin_q, enfin_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               strobe_c;
  logic               addr_bad_c;
  logic               sck_w;
  logic               rise_tick_c;
  logic               fall_tick_c;

`ifdef SHIFT_READBACK_EN
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
`else
  logic               rise_unused_c;
  assign rise_unused_c = rise_tick_c;
`endif

  shift_reg_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i       (CLK),
    .rst_i       (RST),
    .en_i        (state_q == SHIFT),
    .sck_o       (sck_w),
    .rise_tick_c (rise_tick_c),
    .fall_tick_c (fall_tick_c)
  );

  // Request rejected when the index is outside the selected bank.
  assign addr_bad_c = (CMD_SEL == SEL_DYN) ? (32'(CMD_ADDR) >= N_DYN)
                                           : (32'(CMD_ADDR) >= N_STAT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    lat_d    = lat_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    sdo_d    = sdo_q;
    dyn_d    = '0;
    stat_d   = '0;
    enfin_d  = 1'b0;
    err_d    = 1'b0;
    strobe_c = 1'b0;
`ifdef SHIFT_READBACK_EN
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          if (addr_bad_c) begin
            err_d = 1'b1;
          end else begin
            state_d = SHIFT;
            shift_d = CMD_DATA;
            sel_d   = CMD_SEL;
            addr_d  = CMD_ADDR;
            bit_d   = '0;
            // First bit is presented with the first SCK low phase.
            sdo_d   = CMD_DATA[FRAME_W-1];
`ifdef SHIFT_READBACK_EN
            rx_d    = '0;
`endif
          end
        end
      end

      SHIFT: begin
`ifdef SHIFT_READBACK_EN
        if (rise_tick_c) begin
          rx_d = {rx_q[FRAME_W-2:0], SDI};
        end
`endif
        // Bit boundary is the SCK falling edge; SDO only moves there.
        if (fall_tick_c) begin
          if (bit_q == BIT_W'(FRAME_W - 1)) begin
            state_d  = LATCH;
            sdo_d    = 1'b0;
            lat_d    = '0;
            strobe_c = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            sdo_d   = shift_q[FRAME_W-2];
          end
        end
      end

      LATCH: begin
        if (lat_q == LAT_W'(LATCH_CYC - 1)) begin
          state_d = DONE;
          enfin_d = 1'b1;
`ifdef SHIFT_READBACK_EN
          rd_data_d  = rx_q;
          rd_valid_d = 1'b1;
`endif
        end else begin
          lat_d    = lat_q + LAT_W'(1);
          strobe_c = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (strobe_c) begin
      if (sel_q == SEL_DYN) begin
        dyn_d = N_DYN'(1) << addr_q;
      end else begin
        stat_d = N_STAT'(1) << addr_q;
      end
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      sel_q   <= SEL_DYN;
      addr_q  <= '0;
      sdo_q   <= 1'b0;
      dyn_q   <= '0;
      stat_q  <= '0;
      enfin_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      sdo_q   <= sdo_d;
      dyn_q   <= dyn_d;
      stat_q  <= stat_d;
      enfin_q <= enfin_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

`ifdef SHIFT_READBACK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
`endif

  assign CMD_READY = ready_q;
  assign SDO       = sdo_q;
  assign SCK       = sck_w;
  assign DYNLATCH  = dyn_q;
  assign STATLATCH = stat_q;
  assign ENFIN     = enfin_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_shift_reg_loader.sv
// Directed bench for shift_reg_loader (default geometry 16/16/88, CLK_DIV=2,
// LATCH_CYC=2). Build with SHIFT_READBACK_EN defined to cover the readback
// ports; SDI is looped back from SDO.
module tb_shift_reg_loader;
  import shift_reg_pkg::*;

  localparam int unsigned FW = 16;
  localparam int unsigned ND = 16;
  localparam int unsigned NS = 88;
  localparam int unsigned AW = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic [FW-1:0] CMD_DATA = '0;
  logic          CMD_SEL = 1'b0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic          SDO;
  logic          SCK;
  logic [ND-1:0] DYNLATCH;
  logic [NS-1:0] STATLATCH;
  logic          ENFIN;
  logic          BUSY;
  logic          ERR;
`ifdef SHIFT_READBACK_EN
  logic [FW-1:0] RD_DATA;
  logic          RD_VALID;
`endif

  int checks = 0;
  int errors = 0;

  shift_reg_loader #(
    .FRAME_W   (FW),
    .N_DYN     (ND),
    .N_STAT    (NS),
    .CLK_DIV   (2),
    .LATCH_CYC (2),
    .ADDR_W    (AW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_DATA  (CMD_DATA),
    .CMD_SEL   (CMD_SEL),
    .CMD_ADDR  (CMD_ADDR),
    .SDO       (SDO),
    .SCK       (SCK),
    .DYNLATCH  (DYNLATCH),
    .STATLATCH (STATLATCH),
    .ENFIN     (ENFIN),
    .BUSY      (BUSY),
`ifdef SHIFT_READBACK_EN
    .SDI       (SDO),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
`endif
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // Passive observer, sampled on the falling edge.
  int            ncyc = 0;
  int            rises = 0;
  int            per4 = 0;
  int            last_rise = -100;
  int            sck_hi = 0;
  int            sdo_chg = 0;
  int            enfin_cnt = 0;
  int            enfin_cyc = 0;
  int            err_cnt = 0;
  int            dyn_hi = 0;
  int            stat_hi = 0;
  int            dyn_last_cyc = 0;
  logic [FW-1:0] sdo_cap = '0;
  logic [ND-1:0] dyn_last = '0;
  logic [NS-1:0] stat_last = '0;
  logic          sck_prev = 1'b0;
  logic          sdo_prev = 1'b0;

  always @(negedge CLK) begin
    ncyc = ncyc + 1;
    if (SCK && !sck_prev) begin
      rises = rises + 1;
      sdo_cap = {sdo_cap[FW-2:0], SDO};
      if (ncyc - last_rise == 4) per4 = per4 + 1;
      last_rise = ncyc;
    end
    if (SCK) sck_hi = sck_hi + 1;
    if (SCK && sck_prev && (SDO != sdo_prev)) sdo_chg = sdo_chg + 1;
    if (ENFIN) begin
      enfin_cnt = enfin_cnt + 1;
      enfin_cyc = ncyc;
    end
    if (ERR) err_cnt = err_cnt + 1;
    if (DYNLATCH != '0) begin
      dyn_hi = dyn_hi + 1;
      dyn_last = DYNLATCH;
      dyn_last_cyc = ncyc;
    end
    if (STATLATCH != '0) begin
      stat_hi = stat_hi + 1;
      stat_last = STATLATCH;
    end
    sck_prev = SCK;
    sdo_prev = SDO;
  end

  task automatic nwait();
    @(negedge CLK);
    #1;
  endtask

  // Present a request; accept edge is the next posedge, cycle 1 is ncyc+1.
  task automatic send(input logic sel, input logic [AW-1:0] addr,
                      input logic [FW-1:0] data, output int acc);
    CMD_VALID = 1'b1;
    CMD_SEL   = sel;
    CMD_ADDR  = addr;
    CMD_DATA  = data;
    acc       = ncyc;
  endtask

  task automatic wait_enfin(input int e0);
    for (int i = 0; i < 300; i++) begin
      if (enfin_cnt != e0) break;
      nwait();
    end
  endtask

  task automatic test_reset();
    repeat (3) nwait();
    checks++;
    if ({CMD_READY, SDO, SCK, ENFIN, BUSY, ERR} !== 6'b0 || DYNLATCH !== '0 || STATLATCH !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/sdo/sck/enfin/busy/err=%b dyn=%h stat=%h required all 0",
               {CMD_READY, SDO, SCK, ENFIN, BUSY, ERR}, DYNLATCH, STATLATCH);
    end
`ifdef SHIFT_READBACK_EN
    checks++;
    if (RD_DATA !== '0 || RD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_readback: rd_data=%h rd_valid=%b required 0/0", RD_DATA, RD_VALID);
    end
`endif
    RST = 1'b0;
    nwait();
    checks++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b required 1/0", CMD_READY, BUSY);
    end
  endtask

  task automatic test_dyn_frame();
    int acc, r0, p0, h0, d0, s0, e0, c0;
    r0 = rises; p0 = per4; h0 = sck_hi; d0 = dyn_hi; s0 = stat_hi; e0 = enfin_cnt; c0 = sdo_chg;
    send(SEL_DYN, 7'd3, 16'hA5C3, acc);
    nwait();
    CMD_VALID = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || CMD_READY !== 1'b0) begin
      errors++;
      $display("FAIL dyn_busy: busy=%b ready=%b required 1/0", BUSY, CMD_READY);
    end
    wait_enfin(e0);
    checks++;
    if (enfin_cnt !== e0 + 1) begin
      errors++;
      $display("FAIL dyn_enfin_timeout: enfin count %0d required %0d", enfin_cnt - e0, 1);
    end
    checks++;
    if (enfin_cyc - acc !== 67) begin
      errors++;
      $display("FAIL dyn_latency: %0d cycles required 67", enfin_cyc - acc);
    end
    checks++;
    if (sdo_cap !== 16'hA5C3 || rises - r0 !== 16) begin
      errors++;
      $display("FAIL dyn_serial: bits=%h rises=%0d required a5c3/16", sdo_cap, rises - r0);
    end
    checks++;
    if (per4 - p0 !== 15 || sck_hi - h0 !== 32 || sdo_chg - c0 !== 0) begin
      errors++;
      $display("FAIL dyn_sck_shape: period4=%0d high=%0d sdo_moves=%0d required 15/32/0",
               per4 - p0, sck_hi - h0, sdo_chg - c0);
    end
    checks++;
    if (dyn_last !== 16'h0008 || dyn_hi - d0 !== 2 || dyn_last_cyc - acc !== 66) begin
      errors++;
      $display("FAIL dyn_latch: value=%h width=%0d last_cyc=%0d required 0008/2/66",
               dyn_last, dyn_hi - d0, dyn_last_cyc - acc);
    end
    checks++;
    if (stat_hi - s0 !== 0) begin
      errors++;
      $display("FAIL dyn_stat_quiet: stat strobe cycles %0d required 0", stat_hi - s0);
    end
    nwait();
    checks++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || ENFIN !== 1'b0) begin
      errors++;
      $display("FAIL dyn_return_idle: ready=%b busy=%b enfin=%b required 1/0/0", CMD_READY, BUSY, ENFIN);
    end
  endtask

  task automatic test_stat_frame();
    int acc, r0, p0, d0, s0, e0;
    logic [NS-1:0] exp_stat;
    exp_stat = NS'(1) << 87;
    r0 = rises; p0 = per4; d0 = dyn_hi; s0 = stat_hi; e0 = enfin_cnt;
    send(SEL_STAT, 7'd87, 16'hFFFF, acc);
    nwait();
    CMD_VALID = 1'b0;
    wait_enfin(e0);
    checks++;
    if (enfin_cnt !== e0 + 1 || enfin_cyc - acc !== 67) begin
      errors++;
      $display("FAIL stat_enfin: count=%0d latency=%0d required 1/67", enfin_cnt - e0, enfin_cyc - acc);
    end
    checks++;
    if (stat_last !== exp_stat || stat_hi - s0 !== 2) begin
      errors++;
      $display("FAIL stat_latch: value=%h width=%0d required %h/2", stat_last, stat_hi - s0, exp_stat);
    end
    checks++;
    if (dyn_hi - d0 !== 0) begin
      errors++;
      $display("FAIL stat_dyn_quiet: dyn strobe cycles %0d required 0", dyn_hi - d0);
    end
    checks++;
    if (rises - r0 !== 16 || per4 - p0 !== 15 || sdo_cap !== 16'hFFFF) begin
      errors++;
      $display("FAIL stat_sck: rises=%0d period4=%0d bits=%h required 16/15/ffff",
               rises - r0, per4 - p0, sdo_cap);
    end
    nwait();
  endtask

  task automatic test_err();
    int acc, r0, e0, er0;
    r0 = rises; e0 = enfin_cnt; er0 = err_cnt;
    send(SEL_DYN, 7'd16, 16'h1234, acc);
    nwait();
    CMD_VALID = 1'b0;
    checks++;
    if (ERR !== 1'b1 || CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL err_dyn16: err=%b ready=%b busy=%b required 1/1/0", ERR, CMD_READY, BUSY);
    end
    nwait();
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: err=%b required 0", ERR);
    end
    send(SEL_STAT, 7'd88, 16'h4321, acc);
    nwait();
    CMD_VALID = 1'b0;
    checks++;
    if (ERR !== 1'b1 || CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL err_stat88: err=%b ready=%b required 1/1", ERR, CMD_READY);
    end
    repeat (10) nwait();
    checks++;
    if (rises - r0 !== 0 || enfin_cnt - e0 !== 0 || err_cnt - er0 !== 2 || SCK !== 1'b0) begin
      errors++;
      $display("FAIL err_no_activity: rises=%0d enfin=%0d errs=%0d sck=%b required 0/0/2/0",
               rises - r0, enfin_cnt - e0, err_cnt - er0, SCK);
    end
  endtask

  task automatic test_back_to_back();
    int acc, e0, e1, er0;
    er0 = err_cnt;
    e0 = enfin_cnt;
    send(SEL_DYN, 7'd15, 16'h1234, acc);
    nwait();
    // Payload changes and VALID toggles while busy must not be captured.
    CMD_DATA = 16'h8001;
    CMD_ADDR = 7'd0;
    repeat (8) nwait();
    CMD_VALID = 1'b0;
    nwait();
    CMD_VALID = 1'b1;
    nwait();
    CMD_VALID = 1'b0;
    checks++;
    if (CMD_READY !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: ready=%b busy=%b required 0/1", CMD_READY, BUSY);
    end
    repeat (3) nwait();
    CMD_VALID = 1'b1;
    wait_enfin(e0);
    checks++;
    if (enfin_cnt !== e0 + 1 || enfin_cyc - acc !== 67 || sdo_cap !== 16'h1234 || dyn_last !== 16'h8000) begin
      errors++;
      $display("FAIL b2b_first: count=%0d latency=%0d bits=%h latch=%h required 1/67/1234/8000",
               enfin_cnt - e0, enfin_cyc - acc, sdo_cap, dyn_last);
    end
    checks++;
    if (CMD_READY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_in_done: ready=%b required 0", CMD_READY);
    end
    e1 = enfin_cyc;
    e0 = enfin_cnt;
    wait_enfin(e0);
    CMD_VALID = 1'b0;
    checks++;
    if (enfin_cnt !== e0 + 1 || enfin_cyc - e1 !== 68) begin
      errors++;
      $display("FAIL b2b_second_timing: count=%0d spacing=%0d required 1/68", enfin_cnt - e0, enfin_cyc - e1);
    end
    checks++;
    if (sdo_cap !== 16'h8001 || dyn_last !== 16'h0001 || err_cnt - er0 !== 0) begin
      errors++;
      $display("FAIL b2b_second_data: bits=%h latch=%h errs=%0d required 8001/0001/0",
               sdo_cap, dyn_last, err_cnt - er0);
    end
    nwait();
  endtask

  task automatic test_reset_mid();
    int acc, r0, e0, d0;
    r0 = rises; e0 = enfin_cnt;
    send(SEL_DYN, 7'd5, 16'hFFFF, acc);
    nwait();
    CMD_VALID = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rises - r0 >= 8) break;
      nwait();
    end
    checks++;
    if (rises - r0 !== 8) begin
      errors++;
      $display("FAIL rst_reach_bit7: rises=%0d required 8", rises - r0);
    end
    RST = 1'b1;
    nwait();
    checks++;
    if ({CMD_READY, SDO, SCK, ENFIN, BUSY, ERR} !== 6'b0 || DYNLATCH !== '0 || STATLATCH !== '0) begin
      errors++;
      $display("FAIL rst_mid_shift: rdy/sdo/sck/enfin/busy/err=%b dyn=%h stat=%h required all 0",
               {CMD_READY, SDO, SCK, ENFIN, BUSY, ERR}, DYNLATCH, STATLATCH);
    end
    RST = 1'b0;
    nwait();
    d0 = dyn_hi;
    send(SEL_DYN, 7'd9, 16'h00FF, acc);
    nwait();
    CMD_VALID = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dyn_hi != d0) break;
      nwait();
    end
    checks++;
    if (DYNLATCH !== 16'h0200) begin
      errors++;
      $display("FAIL rst_latch_seen: dyn=%h required 0200", DYNLATCH);
    end
    RST = 1'b1;
    nwait();
    checks++;
    if (DYNLATCH !== '0 || BUSY !== 1'b0 || ENFIN !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_latch: dyn=%h busy=%b enfin=%b required 0/0/0", DYNLATCH, BUSY, ENFIN);
    end
    RST = 1'b0;
    repeat (80) nwait();
    checks++;
    if (enfin_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL rst_no_enfin: enfin count %0d required 0", enfin_cnt - e0);
    end
    send(SEL_DYN, 7'd0, 16'h0F0F, acc);
    nwait();
    CMD_VALID = 1'b0;
    wait_enfin(e0);
    checks++;
    if (enfin_cnt !== e0 + 1 || enfin_cyc - acc !== 67 || sdo_cap !== 16'h0F0F || dyn_last !== 16'h0001) begin
      errors++;
      $display("FAIL rst_recovery: count=%0d latency=%0d bits=%h latch=%h required 1/67/0f0f/0001",
               enfin_cnt - e0, enfin_cyc - acc, sdo_cap, dyn_last);
    end
    nwait();
  endtask

`ifdef SHIFT_READBACK_EN
  task automatic test_readback();
    int acc, e0;
    e0 = enfin_cnt;
    send(SEL_STAT, 7'd0, 16'h5A3C, acc);
    nwait();
    CMD_VALID = 1'b0;
    wait_enfin(e0);
    checks++;
    if (ENFIN !== 1'b1 || RD_VALID !== 1'b1 || RD_DATA !== 16'h5A3C) begin
      errors++;
      $display("FAIL readback_frame: enfin=%b rd_valid=%b rd_data=%h required 1/1/5a3c",
               ENFIN, RD_VALID, RD_DATA);
    end
    nwait();
    checks++;
    if (RD_VALID !== 1'b0 || RD_DATA !== 16'h5A3C) begin
      errors++;
      $display("FAIL readback_hold: rd_valid=%b rd_data=%h required 0/5a3c", RD_VALID, RD_DATA);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_dyn_frame();
    test_stat_frame();
    test_err();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
